stage_ex_md: RTL and testbench

Parametrised execute stage for the RISC-V pipeline. It adds RV32M multiply/divide to the existing single-cycle ULA path. ULA operations (forwarding muxes, ula_src mux, ula_control decode, branch target, store data) stay combinational. MUL/DIV operations run on an iterative unit that stalls the front of the pipeline until the result is ready. It sits between the ID/EX and EX/MEM registers; its stall output freezes PC, IF/ID and ID/EX.

---
 rtl/stage_ex_md.sv | 243 ++++++++++++++++++++++++
 tb/tb_stage_ex_md.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/stage_ex_md.sv
// rtl/stage_ex_md.sv - execute stage: combinational ULA plus iterative RV32M multiply/divide
// Stalls the front of the pipeline while a MUL/DIV runs and presents the result for one cycle.
module stage_ex_md #(
  parameter int XLEN     = 32,
  parameter int FAST_MUL = 0,
  parameter int FWD_W    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic             flush,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  reg_data1,
  input  logic [XLEN-1:0]  reg_data2,
  input  logic [XLEN-1:0]  immediate,
  input  logic [1:0]       ula_op,
  input  logic [2:0]       funct3,
  input  logic             funct7_bit5,
  input  logic             is_muldiv,
  input  logic             ula_src,
  input  logic [FWD_W-1:0] ForwardA,
  input  logic [FWD_W-1:0] ForwardB,
  input  logic [XLEN-1:0]  forward_exmem,
  input  logic [XLEN-1:0]  forward_memwb,
  output logic [XLEN-1:0]  ula_result,
  output logic [2:0]       ula_flags,
  output logic [XLEN-1:0]  branch_target,
  output logic [XLEN-1:0]  store_data,
  output logic             valid_out,
  output logic             stall
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        f3_q, f3_d;
  logic              neg_a_q, neg_a_d, neg_b_q, neg_b_d;

  logic [XLEN-1:0]   fwd_a, fwd_b, op_b, add_res, sub_res, alu_res;
  logic              add_ovf, sub_ovf, alu_ovf;
  logic [CNT_W-1:0]  shamt;

  always_comb begin
    fwd_a = reg_data1;
    if (ForwardA == FWD_W'(1))      fwd_a = forward_memwb;
    else if (ForwardA == FWD_W'(2)) fwd_a = forward_exmem;
    fwd_b = reg_data2;
    if (ForwardB == FWD_W'(1))      fwd_b = forward_memwb;
    else if (ForwardB == FWD_W'(2)) fwd_b = forward_exmem;
  end

  assign op_b          = ula_src ? immediate : fwd_b;
  assign add_res       = fwd_a + op_b;
  assign sub_res       = fwd_a - op_b;
  assign add_ovf       = (fwd_a[XLEN-1] == op_b[XLEN-1]) && (add_res[XLEN-1] != fwd_a[XLEN-1]);
  assign sub_ovf       = (fwd_a[XLEN-1] != op_b[XLEN-1]) && (sub_res[XLEN-1] != fwd_a[XLEN-1]);
  assign shamt         = op_b[CNT_W-1:0];
  assign branch_target = pc + immediate;
  assign store_data    = fwd_b;

  // ula_op: 00 add (load/store), 01 sub (branch), 10 funct3 decode, 11 pass operand B
  always_comb begin
    alu_res = add_res;
    alu_ovf = add_ovf;
    case (ula_op)
      2'b00: ;
      2'b01: begin
        alu_res = sub_res;
        alu_ovf = sub_ovf;
      end
      2'b10: begin
        alu_ovf = 1'b0;
        case (funct3)
          3'b000: begin
            if (funct7_bit5 && !ula_src) begin
              alu_res = sub_res;
              alu_ovf = sub_ovf;
            end else begin
              alu_ovf = add_ovf;
            end
          end
          3'b001: alu_res = fwd_a << shamt;
          3'b010: alu_res = {{(XLEN-1){1'b0}}, $signed(fwd_a) < $signed(op_b)};
          3'b011: alu_res = {{(XLEN-1){1'b0}}, fwd_a < op_b};
          3'b100: alu_res = fwd_a ^ op_b;
          3'b101: begin
            if (funct7_bit5) alu_res = $signed(fwd_a) >>> shamt;
            else             alu_res = fwd_a >> shamt;
          end
          3'b110: alu_res = fwd_a | op_b;
          default: alu_res = fwd_a & op_b;
        endcase
      end
      default: begin
        alu_res = op_b;
        alu_ovf = 1'b0;
      end
    endcase
  end

  logic              sgn_a, sgn_b, na, nb, div_zero, div_ovf, md_req;
  logic [XLEN-1:0]   mag_a, mag_b, quo, rem;
  logic [XLEN:0]     rem_part, div_diff, mul_sum;
  logic [2*XLEN-1:0] div_step, mul_step, step, fin, prod_s;

  assign sgn_a    = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b100) || (funct3 == 3'b110);
  assign sgn_b    = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
  assign na       = sgn_a & fwd_a[XLEN-1];
  assign nb       = sgn_b & fwd_b[XLEN-1];
  assign mag_a    = na ? -fwd_a : fwd_a;
  assign mag_b    = nb ? -fwd_b : fwd_b;
  assign div_zero = (fwd_b == '0);
  assign div_ovf  = !funct3[0] && (fwd_a == MIN_INT) && (fwd_b == '1);
  assign md_req   = valid_in & is_muldiv;

  // Restoring division: acc = {remainder, dividend bits still to shift}; top bit of diff is the borrow.
  assign rem_part = acc_q[2*XLEN-1:XLEN-1];
  assign div_diff = rem_part - {1'b0, b_q};
  assign div_step = div_diff[XLEN] ? {rem_part[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                   : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
  // Shift-add multiply: acc = {partial product, multiplier bits still to consume}.
  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, a_q} : {(XLEN+1){1'b0}});
  assign mul_step = {mul_sum, acc_q[XLEN-1:1]};
  assign step     = f3_q[2] ? div_step : mul_step;

  always_comb begin
    fin = step;
    if (FAST_MUL != 0 && !f3_q[2]) fin = {{XLEN{1'b0}}, a_q} * {{XLEN{1'b0}}, b_q};
  end

  assign prod_s = (neg_a_q ^ neg_b_q) ? -fin : fin;
  assign quo    = fin[XLEN-1:0];
  assign rem    = fin[2*XLEN-1:XLEN];

  logic [XLEN-1:0] fixed;
  always_comb begin
    case (f3_q)
      3'b000:          fixed = prod_s[XLEN-1:0];
      3'b100, 3'b101:  fixed = (neg_a_q ^ neg_b_q) ? -quo : quo;
      3'b110, 3'b111:  fixed = neg_a_q ? -rem : rem;
      default:         fixed = prod_s[2*XLEN-1:XLEN];
    endcase
  end

  logic v_int, s_int;
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    res_d      = res_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    f3_d       = f3_q;
    neg_a_d    = neg_a_q;
    neg_b_d    = neg_b_q;
    v_int      = 1'b0;
    s_int      = 1'b0;
    ula_result = alu_res;
    ula_flags  = {alu_ovf, alu_res[XLEN-1], alu_res == '0};
    case (state_q)
      S_IDLE: begin
        if (md_req) begin
          s_int = ~flush;
          if (!flush) begin
            a_d     = mag_a;
            b_d     = mag_b;
            f3_d    = funct3;
            neg_a_d = na;
            neg_b_d = nb;
            cnt_d   = '0;
            if (funct3[2] && div_zero) begin
              res_d   = funct3[1] ? fwd_a : '1;
              state_d = S_DONE;
            end else if (funct3[2] && div_ovf) begin
              res_d   = funct3[1] ? '0 : MIN_INT;
              state_d = S_DONE;
            end else begin
              acc_d   = {{XLEN{1'b0}}, funct3[2] ? mag_a : mag_b};
              state_d = S_BUSY;
            end
          end
        end else begin
          v_int = valid_in;
        end
      end
      S_BUSY: begin
        s_int = 1'b1;
        acc_d = step;
        cnt_d = cnt_q + 1'b1;
        if (flush) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST || (FAST_MUL != 0 && !f3_q[2])) begin
          res_d   = fixed;
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        v_int      = ~flush;
        ula_result = res_q;
        ula_flags  = {1'b0, res_q[XLEN-1], res_q == '0};
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign valid_out = rst_n & v_int;
  assign stall     = rst_n & s_int;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      f3_q    <= '0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      f3_q    <= f3_d;
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
    end
  end

endmodule

// File: tb/tb_stage_ex_md.sv
// tb/tb_stage_ex_md.sv - scoreboard bench for stage_ex_md
// Expected results are queued at issue and popped when valid_out fires.
module tb_stage_ex_md;

  localparam logic [31:0] MIN_INT = 32'h8000_0000;

  logic        clk;
  logic        rst_n, valid_in, flush, funct7_bit5, is_muldiv, ula_src;
  logic [31:0] pc, reg_data1, reg_data2, immediate, forward_exmem, forward_memwb;
  logic [1:0]  ula_op, ForwardA, ForwardB;
  logic [2:0]  funct3;
  logic [31:0] ula_result, branch_target, store_data;
  logic [2:0]  ula_flags;
  logic        valid_out, stall;

  int          n_tests;
  int          n_fail;
  logic [31:0] sb_q[$];

  stage_ex_md #(.XLEN(32), .FAST_MUL(0), .FWD_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .flush(flush), .pc(pc),
    .reg_data1(reg_data1), .reg_data2(reg_data2), .immediate(immediate),
    .ula_op(ula_op), .funct3(funct3), .funct7_bit5(funct7_bit5), .is_muldiv(is_muldiv),
    .ula_src(ula_src), .ForwardA(ForwardA), .ForwardB(ForwardB),
    .forward_exmem(forward_exmem), .forward_memwb(forward_memwb),
    .ula_result(ula_result), .ula_flags(ula_flags), .branch_target(branch_target),
    .store_data(store_data), .valid_out(valid_out), .stall(stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] md_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ua, ub, sa, sbx, p;
    logic [31:0] r;
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    sa  = {{32{a[31]}}, a};
    sbx = {{32{b[31]}}, b};
    p   = '0;
    r   = '0;
    case (f3)
      3'd0: begin p = ua * ub;  r = p[31:0];  end
      3'd1: begin p = sa * sbx; r = p[63:32]; end
      3'd2: begin p = sa * ub;  r = p[63:32]; end
      3'd3: begin p = ua * ub;  r = p[63:32]; end
      3'd4: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else if (a == MIN_INT && b == 32'hFFFF_FFFF) r = MIN_INT;
        else r = $signed(a) / $signed(b);
      end
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) r = a;
        else if (a == MIN_INT && b == 32'hFFFF_FFFF) r = 32'h0;
        else r = $signed(a) % $signed(b);
      end
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  task automatic idle_inputs();
    valid_in = 0; is_muldiv = 0; flush = 0; ForwardA = 0; ForwardB = 0;
    ula_src = 0; ula_op = 0; funct3 = 0; funct7_bit5 = 0;
  endtask

  task automatic do_alu(input string tag, input logic [1:0] op, input logic [2:0] f3, input logic f7,
                        input logic src, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] imm, input logic [31:0] exp);
    @(negedge clk);
    valid_in = 1; is_muldiv = 0; ula_op = op; funct3 = f3; funct7_bit5 = f7; ula_src = src;
    ForwardA = 2'b10; forward_exmem = a; reg_data1 = ~a;
    ForwardB = 2'b00; reg_data2 = b; immediate = imm; pc = 32'h0000_1000 + {a[7:0], 2'b00};
    sb_q.push_back(exp);
    #1;
    chk({tag, "_valid"}, {31'b0, valid_out}, 32'd1);
    chk({tag, "_stall"}, {31'b0, stall}, 32'd0);
    if (valid_out) begin
      chk({tag, "_res"}, ula_result, sb_q.pop_front());
      chk({tag, "_flags"}, {30'b0, ula_flags[1:0]}, {30'b0, exp[31], exp == 0});
    end
    chk({tag, "_btgt"}, branch_target, pc + imm);
    chk({tag, "_sdata"}, store_data, b);
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic do_md(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] exp;
    int          exp_st, st, cyc;
    bit          got;
    exp    = md_model(f3, a, b);
    exp_st = (f3[2] && (b == 0 || (!f3[0] && a == MIN_INT && b == 32'hFFFF_FFFF))) ? 1 : 33;
    @(negedge clk);
    valid_in = 1; is_muldiv = 1; funct3 = f3; funct7_bit5 = 0; ula_op = 2'b10;
    ula_src = 1; immediate = 32'h0000_5a5a;
    ForwardA = 2'b10; forward_exmem = a; reg_data1 = ~a;
    ForwardB = 2'b01; forward_memwb = b; reg_data2 = ~b;
    sb_q.push_back(exp);
    st = 0; cyc = 0; got = 0;
    while (!got && cyc < 100) begin
      #1;
      if (valid_out) begin
        got = 1;
      end else begin
        if (stall) st++;
        cyc++;
        @(negedge clk);
        forward_exmem = $urandom;
        forward_memwb = $urandom;
      end
    end
    if (got) begin
      chk({tag, "_res"}, ula_result, sb_q.pop_front());
      chk({tag, "_flags"}, {29'b0, ula_flags}, {29'b0, 1'b0, exp[31], exp == 0});
      chk({tag, "_stall_done"}, {31'b0, stall}, 32'd0);
    end else begin
      chk({tag, "_timeout"}, 32'd0, 32'd1);
      sb_q.delete(0);
    end
    chk({tag, "_stall_cycles"}, 32'(st), 32'(exp_st));
    @(negedge clk);
    idle_inputs();
    #1;
    chk({tag, "_one_shot"}, {31'b0, valid_out}, 32'd0);
  endtask

  initial begin
    int seen;
    n_tests = 0;
    n_fail  = 0;
    pc = 0; reg_data1 = 0; reg_data2 = 0; immediate = 0; forward_exmem = 0; forward_memwb = 0;
    idle_inputs();
    rst_n = 0;
    valid_in = 1; is_muldiv = 1;
    #1;
    chk("reset_stall", {31'b0, stall}, 32'd0);
    chk("reset_valid", {31'b0, valid_out}, 32'd0);
    repeat (2) @(negedge clk);
    idle_inputs();
    rst_n = 1;
    #1;
    chk("idle_valid", {31'b0, valid_out}, 32'd0);

    do_alu("add_fwd", 2'b10, 3'b000, 1'b0, 1'b0, 32'd5, 32'd3, 32'h40, 32'd8);
    do_alu("sub_br", 2'b01, 3'b000, 1'b0, 1'b0, 32'd10, 32'd3, 32'hFFFF_FFF0, 32'd7);
    do_alu("addi", 2'b10, 3'b000, 1'b1, 1'b1, 32'd5, 32'd9, 32'hFFFF_FFFF, 32'd4);
    do_alu("sra", 2'b10, 3'b101, 1'b1, 1'b0, 32'h8000_0000, 32'd4, 32'h0, 32'hF800_0000);
    do_alu("slt", 2'b10, 3'b010, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h8, 32'd1);
    do_alu("and0", 2'b10, 3'b111, 1'b0, 1'b0, 32'h0000_00F0, 32'h0000_000F, 32'h4, 32'd0);

    do_md("mul", 3'd0, 32'd7, 32'hFFFF_FFFD);
    do_md("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_md("mulh", 3'd1, 32'h8000_0000, 32'h8000_0000);
    do_md("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_md("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    do_md("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
    do_md("divu_0", 3'd5, 32'd5, 32'd0);
    do_md("rem_0", 3'd6, 32'd7, 32'd0);
    do_md("rem_neg", 3'd6, 32'hFFFF_FFF9, 32'd2);
    do_md("div_neg", 3'd4, 32'hFFFF_FF9C, 32'd7);

    // flush in the tenth BUSY cycle of DIVU 100/7
    @(negedge clk);
    valid_in = 1; is_muldiv = 1; funct3 = 3'd5; ula_op = 2'b10;
    ForwardA = 2'b00; ForwardB = 2'b00; reg_data1 = 32'd100; reg_data2 = 32'd7;
    #1;
    chk("flush_start_stall", {31'b0, stall}, 32'd1);
    repeat (10) @(negedge clk);
    flush = 1;
    #1;
    chk("flush_busy_stall", {31'b0, stall}, 32'd1);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("flush_stall_drop", {31'b0, stall}, 32'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (valid_out || stall) seen++;
    end
    chk("flush_no_valid", 32'(seen), 32'd0);
    do_alu("add_after_flush", 2'b10, 3'b000, 1'b0, 1'b0, 32'd20, 32'd22, 32'h10, 32'd42);

    // reset asserted mid-BUSY
    @(negedge clk);
    valid_in = 1; is_muldiv = 1; funct3 = 3'd0; ula_op = 2'b10;
    ForwardA = 2'b00; ForwardB = 2'b00; reg_data1 = 32'd9; reg_data2 = 32'd9;
    repeat (5) @(negedge clk);
    rst_n = 0;
    #1;
    chk("rst_mid_stall", {31'b0, stall}, 32'd0);
    chk("rst_mid_valid", {31'b0, valid_out}, 32'd0);
    @(negedge clk);
    idle_inputs();
    rst_n = 1;
    #1;
    chk("rst_rel_stall", {31'b0, stall}, 32'd0);
    do_md("mul_after_rst", 3'd0, 32'd3, 32'd4);

    for (int i = 0; i < 8; i++) begin
      logic [2:0]  f3;
      logic [31:0] a, b;
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = (i % 3 == 0) ? 32'($urandom_range(1, 9)) : $urandom;
      if (i == 5) b = 32'd0;
      do_md("rand", f3, a, b);
    end

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
